serial_pattern_gen: RTL and testbench
=====================================

# serial_pattern_gen

Serial pattern transmitter: latches a pattern word, a length, a repeat count and an inter-packet gap, then drives them one bit per enabled clock onto a serial line. It is the transmit-side companion of the serial pattern detector and is used as an on-chip stimulus source and loopback driver. Bit order is chosen so that a receiver shifting `{sr[N-2:0], din}` holds `pat[i]` in `sr[i]` after the last bit.

## Interface
Parameters:
- `MAX_LEN`, 8: width of `pat`; maximum legal packet length.
- `LEN_W`, 4: width of `pat_len`.
- `REP_W`, 4: width of `rep_cnt`.
- `GAP_W`, 4: width of `gap_len`.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk` in 1: clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `ena` in 1: clock enable; when 0, all state and outputs hold.
- `start` in 1: request transmission; sampled only in IDLE.
- `abort` in 1: synchronous cancel; has priority over every other input except reset.
- `pat` in MAX_LEN: pattern bits.
- `pat_len` in LEN_W: packet length; legal range 1..MAX_LEN.
- `rep_cnt` in REP_W: extra repeats; total packets R = `rep_cnt` + 1.
- `gap_len` in GAP_W: idle cycles between packets (0..2^GAP_W−1).
- `dout` out 1: serial data, registered.
- `dout_valid` out 1: high while `dout` carries a pattern bit.
- `busy` out 1: high from the first bit cycle through the last bit cycle.
- `done` out 1: one-cycle pulse after the final bit of the final packet.
- `err_len` out 1: one-cycle pulse when `start` is rejected for an illegal `pat_len`.

## Operation
- States: IDLE, SEND, GAP, DONE. All outputs are registered. Reset forces IDLE and drives every output to 0. Internal registers reset to 0, except the LFSR (see Configuration).
- IDLE: `dout`=0, `dout_valid`=0, `busy`=0.
  - On `start`=1 with legal length: latch `pat`, `pat_len`, `rep_cnt`, `gap_len`, and enter SEND.
  - On `start`=1 with `pat_len`=0 or `pat_len`>MAX_LEN: pulse `err_len` and stay in IDLE.
- SEND: bit index runs from `len`−1 down to 0, so `pat_q[len-1]` goes first and `pat_q[0]` goes last. `dout_valid`=1 and `busy`=1.
  - After index 0, if no packets remain: go to DONE.
  - After index 0, if `gap_q`=0: reload the index and stay in SEND, so packets go back-to-back.
  - Otherwise: go to GAP.
- GAP: lasts `gap_q` cycles. `dout_valid`=0 and `busy`=1; `dout` is 0 (but see Configuration). The state then returns to SEND with the index reloaded.
- DONE: `done`=1 for one cycle with `busy`=0 and `dout`=0. The state then returns to IDLE.
- `start` is ignored outside IDLE. Inputs changing mid-transmission have no effect, because the latched copies are used.
- `abort`=1 in any state: go to IDLE on the next enabled edge. All outputs go to 0 and no `done` pulse is generated.
- `ena`=0: the FSM, counters and LFSR freeze, and outputs hold their values, including a `done` or `err_len` level already asserted. Every cycle count in this document counts enabled cycles only.
- Reset mid-transmission: immediate return to IDLE with all outputs 0.

## Timing
- Let `start` be sampled at edge k. Bit j of packet p (p = 0..R−1) is on `dout` during cycle k+1+p·(len+gap)+j.
- Total occupancy T = R·len + (R−1)·gap cycles. `busy` is high for cycles k+1 .. k+T.
- `done` is high in cycle k+T+1.
- The earliest next `start` is sampled at edge k+T+2, i.e. one cycle after the IDLE state is re-entered.
- `err_len` is high in cycle k+1.
- After an `abort` sampled at edge a, outputs are 0 in cycle a+1.

## Configuration
- `SPG_LFSR_GAP_EN` defined: during GAP, `dout` = `lfsr[0]`. This fills gaps with noise so receivers can be stress-tested for false matches.
  - The LFSR is 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - It resets to 8'hA5 and advances once per enabled GAP cycle only.
  - `dout_valid` stays 0 during GAP.
- `SPG_LFSR_GAP_EN` undefined: no LFSR is built, and `dout`=0 during GAP.

## Test plan
- `pat`=8'h0D, `pat_len`=4, `rep_cnt`=0, start at edge k → `dout`=1,1,0,1 in cycles k+1..k+4; `busy` high for those cycles; `done` in cycle k+5; `busy` low in cycle k+5.
- `pat`=8'h05, `pat_len`=3, `rep_cnt`=2, `gap_len`=3 → T=15; bit pattern 101,000,101,000,101 with `dout_valid` low during the zeros; `done` in cycle k+16.
- `pat_len`=0, then `pat_len`=9 → each attempt pulses `err_len` for one cycle; `busy`, `dout_valid` and `done` stay 0.
- `ena` low for 2 cycles during bit 1 of a 4-bit packet → that bit is held for 3 clocks; `done` is delayed by exactly 2 clocks; `start` asserted mid-packet is ignored.
- `abort` at bit 2 of packet 0 with `rep_cnt`=3 → IDLE next cycle, all outputs 0, no `done`. Then assert `rst_n`=0 mid-packet on a second transmission → outputs are 0 asynchronously.
- With `SPG_LFSR_GAP_EN`, `gap_len`=8 → gap bits equal the first 8 `lfsr[0]` values of the sequence seeded with 8'hA5; `dout_valid`=0 throughout the gap.

Source files
------------

// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: sends pat[len-1..0] MSB-first, rep_cnt+1 times with gap_len idle cycles between packets.
// Optional SPG_LFSR_GAP_EN fills gap cycles with LFSR noise (x^8+x^6+x^5+x^4+1, seed 8'hA5).
module serial_pattern_gen #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic [REP_W-1:0]   rep_cnt,
  input  logic [GAP_W-1:0]   gap_len,
  output logic               dout,
  output logic               dout_valid,
  output logic               busy,
  output logic               done,
  output logic               err_len
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W:0] MAX_LEN_C = (LEN_W + 1)'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               len_ok;
  logic [IDX_W-1:0]   idx_first;
  logic [IDX_W-1:0]   idx_reload;
  logic [IDX_W-1:0]   idx_dec;

`ifdef SPG_LFSR_GAP_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] lfsr_step;
  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif

  assign len_ok     = (pat_len != '0) && ({1'b0, pat_len} <= MAX_LEN_C);
  assign idx_first  = IDX_W'(pat_len - 1'b1);
  assign idx_reload = IDX_W'(len_q - 1'b1);
  assign idx_dec    = idx_q - 1'b1;

  // Outputs are computed for the cycle being entered and registered, so dout tracks state_q with no extra lag.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef SPG_LFSR_GAP_EN
    lfsr_d  = lfsr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            pat_d   = pat;
            len_d   = pat_len;
            rep_d   = rep_cnt;
            gap_d   = gap_len;
            idx_d   = idx_first;
            state_d = SEND;
            dout_d  = pat[idx_first];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (idx_q != '0) begin
          idx_d   = idx_dec;
          dout_d  = pat_q[idx_dec];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (rep_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          rep_d = rep_q - 1'b1;
          if (gap_q == '0) begin
            idx_d   = idx_reload;
            dout_d  = pat_q[idx_reload];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = GAP;
            gcnt_d  = gap_q;
            busy_d  = 1'b1;
`ifdef SPG_LFSR_GAP_EN
            dout_d  = lfsr_q[0];
`endif
          end
        end
      end
      GAP: begin
`ifdef SPG_LFSR_GAP_EN
        lfsr_d = lfsr_step;
`endif
        if (gcnt_q == GAP_W'(1)) begin
          state_d = SEND;
          idx_d   = idx_reload;
          dout_d  = pat_q[idx_reload];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          gcnt_d = gcnt_q - 1'b1;
          busy_d = 1'b1;
`ifdef SPG_LFSR_GAP_EN
          dout_d = lfsr_step[0];
`endif
        end
      end
      DONE: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      dout_d  = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SPG_LFSR_GAP_EN
      lfsr_q  <= 8'hA5;
`endif
    end else if (ena) begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SPG_LFSR_GAP_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_len    = err_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed table-driven bench for serial_pattern_gen; outputs packed as {dout, dout_valid, busy, done, err_len}.
module tb_serial_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n, ena, start, abort;
  logic [7:0] pat;
  logic [3:0] pat_len, rep_cnt, gap_len;
  logic       dout, dout_valid, busy, done, err_len;

  always #5 clk = ~clk;

  serial_pattern_gen #(.MAX_LEN(8), .LEN_W(4), .REP_W(4), .GAP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
    .pat(pat), .pat_len(pat_len), .rep_cnt(rep_cnt), .gap_len(gap_len),
    .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done), .err_len(err_len)
  );

  localparam logic [4:0] S1 = 5'b11100; // bit 1 on the line
  localparam logic [4:0] S0 = 5'b01100; // bit 0 on the line
  localparam logic [4:0] G  = 5'b00100; // gap cycle
  localparam logic [4:0] D  = 5'b00010; // done pulse
  localparam logic [4:0] E  = 5'b00001; // err_len pulse
  localparam logic [4:0] I  = 5'b00000; // idle

  typedef struct {
    logic       st;
    logic       ab;
    logic [7:0] p;
    logic [3:0] l, r, g;
    logic [4:0] exp;
  } vec_t;

  vec_t vq[$];
  int   errs = 0;
  int   checks = 0;

  function automatic vec_t v(input logic st, input logic ab, input logic [7:0] p,
                             input logic [3:0] l, input logic [3:0] r, input logic [3:0] g,
                             input logic [4:0] exp);
    vec_t x;
    x.st = st; x.ab = ab; x.p = p; x.l = l; x.r = r; x.g = g; x.exp = exp;
    return x;
  endfunction

  function automatic logic [4:0] obs();
    return {dout, dout_valid, busy, done, err_len};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic st, input logic ab);
    ena = e; start = st; abort = ab;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [4:0] got;
    logic [7:0] l;

    rst_n = 1'b0; ena = 1'b0; start = 1'b0; abort = 1'b0;
    pat = '0; pat_len = '0; rep_cnt = '0; gap_len = '0;
    #12;
    check("reset", obs(), I);
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0);

    // Single 4-bit packet; later vectors drive junk inputs that must be ignored.
    vq.push_back(v(1, 0, 8'h0D, 4, 0, 0, S1));
    vq.push_back(v(0, 0, 8'hF2, 7, 5, 2, S1));
    vq.push_back(v(0, 0, 8'hF2, 7, 5, 2, S0));
    vq.push_back(v(0, 0, 8'hF2, 7, 5, 2, S1));
    vq.push_back(v(0, 0, 8'hF2, 7, 5, 2, D));
    vq.push_back(v(0, 0, 8'hF2, 7, 5, 2, I));
    // Three packets of 101 with 3-cycle gaps: T=15, done in cycle k+16.
    vq.push_back(v(1, 0, 8'h05, 3, 2, 3, S1));
    vq.push_back(v(0, 0, 8'hFA, 1, 0, 0, S0));
    vq.push_back(v(0, 0, 8'hFA, 1, 0, 0, S1));
    for (int i = 0; i < 3; i++) vq.push_back(v(0, 0, 8'h00, 0, 0, 0, G));
    vq.push_back(v(0, 0, 8'h00, 0, 0, 0, S1));
    vq.push_back(v(0, 0, 8'h00, 0, 0, 0, S0));
    vq.push_back(v(0, 0, 8'h00, 0, 0, 0, S1));
    for (int i = 0; i < 3; i++) vq.push_back(v(0, 0, 8'h00, 0, 0, 0, G));
    vq.push_back(v(0, 0, 8'h00, 0, 0, 0, S1));
    vq.push_back(v(0, 0, 8'h00, 0, 0, 0, S0));
    vq.push_back(v(0, 0, 8'h00, 0, 0, 0, S1));
    vq.push_back(v(0, 0, 8'h00, 0, 0, 0, D));
    vq.push_back(v(0, 0, 8'h00, 0, 0, 0, I));
    // Illegal lengths 0 and 9.
    vq.push_back(v(1, 0, 8'hFF, 0, 0, 0, E));
    vq.push_back(v(0, 0, 8'hFF, 0, 0, 0, I));
    vq.push_back(v(1, 0, 8'hFF, 9, 0, 0, E));
    vq.push_back(v(0, 0, 8'hFF, 9, 0, 0, I));
    // Back-to-back packets (gap 0): 10,10.
    vq.push_back(v(1, 0, 8'h02, 2, 1, 0, S1));
    vq.push_back(v(0, 0, 8'h00, 0, 0, 0, S0));
    vq.push_back(v(0, 0, 8'h00, 0, 0, 0, S1));
    vq.push_back(v(0, 0, 8'h00, 0, 0, 0, S0));
    vq.push_back(v(0, 0, 8'h00, 0, 0, 0, D));
    vq.push_back(v(0, 0, 8'h00, 0, 0, 0, I));

    foreach (vq[i]) begin
      pat = vq[i].p; pat_len = vq[i].l; rep_cnt = vq[i].r; gap_len = vq[i].g;
      step(1'b1, vq[i].st, vq[i].ab);
      got = obs();
`ifdef SPG_LFSR_GAP_EN
      if (vq[i].exp == G) got[4] = 1'b0;
`endif
      check($sformatf("vec%0d", i), got, vq[i].exp);
    end

    // Clock enable low for two cycles during bit 1; mid-packet start ignored.
    pat = 8'h0D; pat_len = 4; rep_cnt = 0; gap_len = 0;
    step(1'b1, 1'b1, 1'b0); check("ena_b0", obs(), S1);
    step(1'b1, 1'b0, 1'b0); check("ena_b1", obs(), S1);
    step(1'b0, 1'b1, 1'b0); check("ena_hold0", obs(), S1);
    step(1'b0, 1'b1, 1'b0); check("ena_hold1", obs(), S1);
    step(1'b1, 1'b1, 1'b0); check("ena_b2", obs(), S0);
    step(1'b1, 1'b0, 1'b0); check("ena_b3", obs(), S1);
    step(1'b1, 1'b0, 1'b0); check("ena_done", obs(), D);
    step(1'b0, 1'b0, 1'b0); check("done_hold", obs(), D);
    step(1'b1, 1'b0, 1'b0); check("ena_idle", obs(), I);

    // Abort during bit 2 of packet 0 with three repeats pending.
    pat = 8'hB6; pat_len = 4; rep_cnt = 3; gap_len = 0;
    step(1'b1, 1'b1, 1'b0); check("ab_b0", obs(), S0);
    step(1'b1, 1'b0, 1'b0); check("ab_b1", obs(), S1);
    step(1'b1, 1'b0, 1'b0); check("ab_b2", obs(), S1);
    step(1'b1, 1'b0, 1'b1); check("abort", obs(), I);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check($sformatf("ab_idle%0d", i), obs(), I);
    end

    // Asynchronous reset mid-packet.
    pat = 8'h0D; pat_len = 4; rep_cnt = 0; gap_len = 0;
    step(1'b1, 1'b1, 1'b0); check("rst_b0", obs(), S1);
    step(1'b1, 1'b0, 1'b0); check("rst_b1", obs(), S1);
    #2 rst_n = 1'b0;
    #1 check("async_rst", obs(), I);
    @(posedge clk); #1 check("rst_held", obs(), I);
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0); check("rst_idle", obs(), I);

`ifdef SPG_LFSR_GAP_EN
    // LFSR freshly seeded by the reset above.
    pat = 8'h01; pat_len = 1; rep_cnt = 1; gap_len = 8;
    step(1'b1, 1'b1, 1'b0); check("lfsr_p0", obs(), S1);
    l = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check($sformatf("lfsr_gap%0d", i), obs(), {l[0], G[3:0]});
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    step(1'b1, 1'b0, 1'b0); check("lfsr_p1", obs(), S1);
    step(1'b1, 1'b0, 1'b0); check("lfsr_done", obs(), D);
`else
    l = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
